muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit and its sequencer for the MIPS EX stage. Executes MULT, MULTU, DIV and DIVU one bit per cycle and owns the HI/LO registers.
- Raises a pipeline stall when a younger MFHI/MFLO or a new mul/div op needs the unit while it is busy.
- Decode supplies op, operands and the request strobes. Hazard logic ORs the stall output into the global stall.

---
 rtl/muldiv_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU)
//             that owns the HI/LO registers. It retires one product or
//             quotient bit per cycle and stalls younger HI/LO consumers and
//             new mul/div ops while it is busy.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            system clock
//    rst            synchronous active-high reset
//    start_i        mul/div instruction in EX this cycle
//    op_i[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//    a_i            rs operand (multiplicand / dividend)
//    b_i            rt operand (multiplier / divisor)
//    hilo_rd_i      MFHI/MFLO in EX this cycle
//    flush_i        abandon the in-flight operation
//    busy_o         operation in progress
//    stall_o        busy_o & (start_i | hilo_rd_i [| mthi_we_i | mtlo_we_i])
//    done_o         one-cycle pulse; HI/LO updated this cycle
//    div_by_zero_o  valid with done_o; divide with b == 0
//    hi_o, lo_o     HI / LO registers
//  Optional (macro MULDIV_MTHILO_EN)
//    mthi_we_i, mtlo_we_i, mt_wdata_i : MTHI/MTLO writes while idle
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hilo_rd_i,
  input  logic             flush_i,
`ifdef MULDIV_MTHILO_EN
  input  logic             mthi_we_i,
  input  logic             mtlo_we_i,
  input  logic [WIDTH-1:0] mt_wdata_i,
`endif
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // FIX applies the sign correction into the working registers; WB then
  // commits them, which keeps the wide negate off the HI/LO write path.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // negate product / quotient
  logic             neg_rem_q, neg_rem_d;   // negate remainder
  logic             bzero_q, bzero_d;       // divisor was zero
  logic [WIDTH-1:0] a_raw_q, a_raw_d;       // original dividend for /0 result
  logic [WIDTH-1:0] mcand_q, mcand_d;       // |multiplicand| or |divisor|
  logic [WIDTH-1:0] acc_q, acc_d;           // upper product half / remainder
  logic [WIDTH-1:0] lo_acc_q, lo_acc_d;     // multiplier->lower half / quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             w_accept;
  logic             w_signed_in;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic             w_wr_req;

  // ---------------------------------------------------------------------------
  // Operand preparation
  // ---------------------------------------------------------------------------
  assign w_accept    = (state_q == S_IDLE) && start_i && !flush_i;
  assign w_signed_in = ~op_i[0];
  assign w_a_neg     = w_signed_in & a_i[WIDTH-1];
  assign w_b_neg     = w_signed_in & b_i[WIDTH-1];
  assign w_a_abs     = w_a_neg ? (~a_i + 1'b1) : a_i;
  assign w_b_abs     = w_b_neg ? (~b_i + 1'b1) : b_i;

  // Shift-add multiply step: add multiplicand when the LSB of the multiplier
  // is set, then shift the {acc, lo_acc} pair right by one.
  assign w_sum = {1'b0, acc_q} + (lo_acc_q[0] ? {1'b0, mcand_q} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract when it fits. The true difference is always below the divisor,
  // so WIDTH bits of the subtraction are sufficient.
  assign w_shift = {acc_q, lo_acc_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, mcand_q});
  assign w_diff  = w_shift[WIDTH-1:0] - mcand_q;

  assign w_prod_neg = ~{acc_q, lo_acc_q} + 1'b1;

`ifdef MULDIV_MTHILO_EN
  assign w_wr_req = mthi_we_i | mtlo_we_i;
`else
  assign w_wr_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o  = (state_q != S_IDLE);
    stall_o = busy_o & (start_i | hilo_rd_i | w_wr_req);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    a_raw_d   = a_raw_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    lo_acc_d  = lo_acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

`ifdef MULDIV_MTHILO_EN
    // Idle writes; a result completing later simply overwrites them.
    if (state_q == S_IDLE) begin
      if (mthi_we_i) hi_d = mt_wdata_i;
      if (mtlo_we_i) lo_d = mt_wdata_i;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          is_div_d  = op_i[1];
          neg_res_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          bzero_d   = (b_i == '0);
          a_raw_d   = a_i;
          mcand_d   = w_b_abs;
          acc_d     = '0;
          lo_acc_d  = w_a_abs;
          cnt_d     = '0;
          dbz_d     = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d    = w_ge ? w_diff : w_shift[WIDTH-1:0];
          lo_acc_d = {lo_acc_q[WIDTH-2:0], w_ge};
        end else begin
          acc_d    = w_sum[WIDTH:1];
          lo_acc_d = {w_sum[0], lo_acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          if (neg_res_q) lo_acc_d = ~lo_acc_q + 1'b1;
          if (neg_rem_q) acc_d    = ~acc_q + 1'b1;
        end else if (neg_res_q) begin
          {acc_d, lo_acc_d} = w_prod_neg;
        end
      end
      S_WB: begin
        if (!flush_i) begin
          done_d = 1'b1;
          if (is_div_q && bzero_q) begin
            hi_d  = a_raw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d  = acc_q;
            lo_d  = lo_acc_q;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_raw_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      lo_acc_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      a_raw_q   <= a_raw_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      lo_acc_q  <= lo_acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer: table of directed
//             mul/div vectors run back to back, plus hand-written sequences
//             for stall, flush and mid-operation reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             hilo_rd_i;
  logic             flush_i;
`ifdef MULDIV_MTHILO_EN
  logic             mthi_we_i;
  logic             mtlo_we_i;
  logic [WIDTH-1:0] mt_wdata_i;
`endif
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic             div_by_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  int n_chk;
  int n_err;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .hilo_rd_i     (hilo_rd_i),
    .flush_i       (flush_i),
`ifdef MULDIV_MTHILO_EN
    .mthi_we_i     (mthi_we_i),
    .mtlo_we_i     (mtlo_we_i),
    .mt_wdata_i    (mt_wdata_i),
`endif
    .busy_o        (busy_o),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issues one op at edge E and returns in the done cycle (E+34).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic ok;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    tick();                       // edge E
    start_i = 1'b0;
    chk({tag, " busy_at_E"}, 64'(busy_o), 64'd1);
    chk({tag, " dbz_cleared"}, 64'(div_by_zero_o), 64'd0);
    ok = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (busy_o !== 1'b1 || done_o !== 1'b0) ok = 1'b0;
    end
    chk({tag, " busy_window"}, 64'(ok), 64'd1);
    tick();                       // edge E+34
    chk({tag, " done_pulse"}, 64'(done_o), 64'd1);
    chk({tag, " busy_low_done"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic ok;
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start_i   = 1'b0;
    op_i      = 2'b00;
    a_i       = '0;
    b_i       = '0;
    hilo_rd_i = 1'b0;
    flush_i   = 1'b0;
`ifdef MULDIV_MTHILO_EN
    mthi_we_i  = 1'b0;
    mtlo_we_i  = 1'b0;
    mt_wdata_i = '0;
`endif

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[6]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_DIV,   32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[13] = '{OP_MULT,  32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1'b0};

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst dbz", 64'(div_by_zero_o), 64'd0);
    chk("rst hi", 64'(hi_o), 64'd0);
    chk("rst lo", 64'(lo_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle stall", 64'(stall_o), 64'd0);

    // ---------------- table, back to back ----------------
    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, tag);
      chk({tag, " hi"}, 64'(hi_o), 64'(vecs[i].exp_hi));
      chk({tag, " lo"}, 64'(lo_o), 64'(vecs[i].exp_lo));
      chk({tag, " dbz"}, 64'(div_by_zero_o), 64'(vecs[i].exp_dbz));
    end
    tick();
    chk("done one cycle", 64'(done_o), 64'd0);

    // ---------------- stall: hilo_rd from E+5, start at E+10 ----------------
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd4;
    tick();                                   // edge E
    start_i = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (stall_o !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("no stall before rd", 64'(ok), 64'd1);
    ok = 1'b1;
    for (int c = 5; c <= 33; c++) begin      // now in cycle E+c
      hilo_rd_i = 1'b1;
      start_i   = (c == 10);
      op_i      = OP_MULTU; a_i = 32'd7; b_i = 32'd7;
      #1;
      if (stall_o !== 1'b1) ok = 1'b0;
      tick();
      start_i = 1'b0;
    end
    chk("stall held E+5..E+33", 64'(ok), 64'd1);
    #1;
    chk("stall drops at done", 64'(stall_o), 64'd0);
    chk("stall done pulse", 64'(done_o), 64'd1);
    chk("stall hi", 64'(hi_o), 64'd0);
    chk("stall lo", 64'(lo_o), 64'd12);
    hilo_rd_i = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
    end
    chk("stalled start ignored", 64'(ok), 64'd1);
    chk("stalled start lo kept", 64'(lo_o), 64'd12);

    // ---------------- flush at E+10 with hi/lo preloaded ----------------
    run_op(OP_DIVU, 32'h5555AAAA, 32'h00010000, "preload");
    chk("preload hi", 64'(hi_o), 64'h0000AAAA);
    chk("preload lo", 64'(lo_o), 64'h00005555);
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'hFFFF; b_i = 32'hFFFF;
    tick();                                   // edge E
    start_i = 1'b0;
    for (int c = 0; c < 10; c++) tick();      // cycle E+10
    flush_i = 1'b1;
    tick();                                   // edge E+11
    flush_i = 1'b0;
    chk("flush busy", 64'(busy_o), 64'd0);
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_o !== 1'b0) ok = 1'b0;
    end
    chk("flush no done", 64'(ok), 64'd1);
    chk("flush hi kept", 64'(hi_o), 64'h0000AAAA);
    chk("flush lo kept", 64'(lo_o), 64'h00005555);

    // flush together with start in IDLE: op not accepted
    start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush+start busy", 64'(busy_o), 64'd0);

    // ---------------- reset mid-operation ----------------
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'h1234; b_i = 32'h5678;
    tick();                                   // edge E
    start_i = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst busy", 64'(busy_o), 64'd0);
    chk("mid rst hi", 64'(hi_o), 64'd0);
    chk("mid rst lo", 64'(lo_o), 64'd0);
    chk("mid rst dbz", 64'(div_by_zero_o), 64'd0);
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_o !== 1'b0 || stall_o !== 1'b0) ok = 1'b0;
    end
    chk("mid rst no done", 64'(ok), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
